stopwatch_bcd_counter: RTL and testbench

- Consumes the one-cycle ENABLE tick from the system enable generator (1 Hz at 12 MHz CLK).
- Counts a BCD minutes:seconds stopwatch from 00:00 to 59:59, then wraps.
- Start/stop and clear are driven from front-panel buttons.
- Digit outputs feed the 7-segment display driver. CARRY feeds a downstream hour counter.

---
 rtl/stopwatch_bcd_counter.sv | 115 +++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// BCD minutes:seconds stopwatch counting ENABLE ticks from 00:00 up to MIN_LIMIT:SEC_LIMIT, then wrapping.
// A rising edge on START_STOP toggles run/stop; CLEAR zeroes the display and stops; CARRY pulses on wrap.
module stopwatch_bcd_counter #(
    parameter int unsigned SEC_LIMIT = 59,
    parameter int unsigned MIN_LIMIT = 59
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       START_STOP,
    input  logic       CLEAR,
    output logic [3:0] SEC_ONE,
    output logic [3:0] SEC_TEN,
    output logic [3:0] MIN_ONE,
    output logic [3:0] MIN_TEN,
    output logic       RUNNING,
    output logic       CARRY
);

    localparam logic [3:0] SecOneLim = 4'(SEC_LIMIT % 10);
    localparam logic [3:0] SecTenLim = 4'(SEC_LIMIT / 10);
    localparam logic [3:0] MinOneLim = 4'(MIN_LIMIT % 10);
    localparam logic [3:0] MinTenLim = 4'(MIN_LIMIT / 10);

    typedef enum logic [0:0] {StStopped, StCounting} state_e;

    state_e     state_q, state_d;
    logic       start_stop_q;
    logic       start_edge;
    logic       count_en;
    logic       sec_at_lim;
    logic       min_at_lim;
    logic [3:0] sec_one_q, sec_one_d;
    logic [3:0] sec_ten_q, sec_ten_d;
    logic [3:0] min_one_q, min_one_d;
    logic [3:0] min_ten_q, min_ten_d;
    logic       carry_q, carry_d;

    assign start_edge = START_STOP & ~start_stop_q;
    // Count decision uses the pre-toggle run state, so a tick on a stop edge still counts.
    assign count_en   = ENABLE & (state_q == StCounting) & ~CLEAR;
    assign sec_at_lim = (sec_ten_q == SecTenLim) && (sec_one_q == SecOneLim);
    assign min_at_lim = (min_ten_q == MinTenLim) && (min_one_q == MinOneLim);

    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = StStopped;
        end else if (start_edge) begin
            state_d = (state_q == StCounting) ? StStopped : StCounting;
        end
    end

    always_comb begin
        sec_one_d = sec_one_q;
        sec_ten_d = sec_ten_q;
        min_one_d = min_one_q;
        min_ten_d = min_ten_q;
        carry_d   = 1'b0;
        if (CLEAR) begin
            sec_one_d = 4'h0;
            sec_ten_d = 4'h0;
            min_one_d = 4'h0;
            min_ten_d = 4'h0;
        end else if (count_en) begin
            if (sec_at_lim) begin
                sec_one_d = 4'h0;
                sec_ten_d = 4'h0;
                if (min_at_lim) begin
                    min_one_d = 4'h0;
                    min_ten_d = 4'h0;
                    carry_d   = 1'b1;
                end else if (min_one_q == 4'd9) begin
                    min_one_d = 4'h0;
                    min_ten_d = min_ten_q + 4'd1;
                end else begin
                    min_one_d = min_one_q + 4'd1;
                end
            end else if (sec_one_q == 4'd9) begin
                sec_one_d = 4'h0;
                sec_ten_d = sec_ten_q + 4'd1;
            end else begin
                sec_one_d = sec_one_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StStopped;
            start_stop_q <= 1'b0;
            sec_one_q    <= 4'h0;
            sec_ten_q    <= 4'h0;
            min_one_q    <= 4'h0;
            min_ten_q    <= 4'h0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_stop_q <= START_STOP;
            sec_one_q    <= sec_one_d;
            sec_ten_q    <= sec_ten_d;
            min_one_q    <= min_one_d;
            min_ten_q    <= min_ten_d;
            carry_q      <= carry_d;
        end
    end

    assign SEC_ONE = sec_one_q;
    assign SEC_TEN = sec_ten_q;
    assign MIN_ONE = min_one_q;
    assign MIN_TEN = min_ten_q;
    assign RUNNING = (state_q == StCounting);
    assign CARRY   = carry_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: counting, wraps, carry, edge/tick interplay, clear, reset.
module tb_stopwatch_bcd_counter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       START_STOP = 1'b0;
    logic       CLEAR = 1'b0;
    logic [3:0] SEC_ONE, SEC_TEN, MIN_ONE, MIN_TEN;
    logic       RUNNING, CARRY;

    int n_tests = 0;
    int n_fail  = 0;
    int carry_cnt = 0;
    int range_bad = 0;

    stopwatch_bcd_counter #(.SEC_LIMIT(59), .MIN_LIMIT(59)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .START_STOP (START_STOP),
        .CLEAR      (CLEAR),
        .SEC_ONE    (SEC_ONE),
        .SEC_TEN    (SEC_TEN),
        .MIN_ONE    (MIN_ONE),
        .MIN_TEN    (MIN_TEN),
        .RUNNING    (RUNNING),
        .CARRY      (CARRY)
    );

    always #5 CLK = ~CLK;

    wire [15:0] disp = {MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE};

    always @(negedge CLK) begin
        if (CARRY) carry_cnt++;
        if (SEC_ONE > 4'd9 || SEC_TEN > 4'd5 || MIN_ONE > 4'd9 || MIN_TEN > 4'd5) range_bad++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ENABLE held for n consecutive cycles; returns on a negedge after the last count.
    task automatic ticks(input int n);
        @(negedge CLK) ENABLE = 1'b1;
        repeat (n) @(negedge CLK);
        ENABLE = 1'b0;
    endtask

    task automatic tick_spaced();
        ticks(1);
        repeat (4) @(negedge CLK);
    endtask

    task automatic press();
        @(negedge CLK) START_STOP = 1'b1;
        @(negedge CLK) START_STOP = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check_eq("reset_disp", 32'(disp), 32'h0000);
        check_eq("reset_run", 32'(RUNNING), 32'h0);
        check_eq("reset_carry", 32'(CARRY), 32'h0);
        RESET = 1'b0;

        // 1: start and 10 spaced ticks
        @(negedge CLK) START_STOP = 1'b1;
        check_eq("run_before_edge", 32'(RUNNING), 32'h0);
        @(negedge CLK);
        check_eq("run_after_edge", 32'(RUNNING), 32'h1);
        START_STOP = 1'b0;
        repeat (10) tick_spaced();
        check_eq("t1_disp_0010", 32'(disp), 32'h0010);
        check_eq("t1_no_carry", 32'(carry_cnt), 32'd0);

        // 2: seconds and minutes rollover
        ticks(49);
        check_eq("t2_disp_0059", 32'(disp), 32'h0059);
        ticks(1);
        check_eq("t2_disp_0100", 32'(disp), 32'h0100);
        ticks(539);
        check_eq("t2_disp_0959", 32'(disp), 32'h0959);
        ticks(1);
        check_eq("t2_disp_1000", 32'(disp), 32'h1000);

        // 3: full wrap with carry
        ticks(2999);
        check_eq("t3_disp_5959", 32'(disp), 32'h5959);
        check_eq("t3_carry_pre", 32'(carry_cnt), 32'd0);
        ticks(1);
        check_eq("t3_disp_wrap", 32'(disp), 32'h0000);
        check_eq("t3_carry_hi", 32'(CARRY), 32'h1);
        @(negedge CLK);
        check_eq("t3_carry_lo", 32'(CARRY), 32'h0);
        check_eq("t3_carry_once", 32'(carry_cnt), 32'd1);
        ticks(1);
        check_eq("t3_disp_0001", 32'(disp), 32'h0001);

        // 4: edge/tick coincidence and held button
        ticks(4);
        press();
        check_eq("t4_stopped", 32'(RUNNING), 32'h0);
        ticks(3);
        check_eq("t4_hold_stopped", 32'(disp), 32'h0005);
        @(negedge CLK) begin START_STOP = 1'b1; ENABLE = 1'b1; end
        @(negedge CLK) begin START_STOP = 1'b0; ENABLE = 1'b0; end
        check_eq("t4_start_tick_disp", 32'(disp), 32'h0005);
        check_eq("t4_start_tick_run", 32'(RUNNING), 32'h1);
        @(negedge CLK) begin START_STOP = 1'b1; ENABLE = 1'b1; end
        @(negedge CLK) begin START_STOP = 1'b0; ENABLE = 1'b0; end
        check_eq("t4_stop_tick_disp", 32'(disp), 32'h0006);
        check_eq("t4_stop_tick_run", 32'(RUNNING), 32'h0);
        @(negedge CLK) START_STOP = 1'b1;
        repeat (100) @(negedge CLK);
        check_eq("t4_held_run", 32'(RUNNING), 32'h1);
        START_STOP = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("t4_release_run", 32'(RUNNING), 32'h1);

        // 5: clear priority
        ticks(748);
        check_eq("t5_disp_1234", 32'(disp), 32'h1234);
        @(negedge CLK) begin CLEAR = 1'b1; ENABLE = 1'b1; START_STOP = 1'b1; end
        @(negedge CLK) START_STOP = 1'b0;
        check_eq("t5_clr_disp", 32'(disp), 32'h0000);
        check_eq("t5_clr_run", 32'(RUNNING), 32'h0);
        check_eq("t5_clr_carry", 32'(CARRY), 32'h0);
        repeat (5) @(negedge CLK);
        check_eq("t5_clr_held_disp", 32'(disp), 32'h0000);
        check_eq("t5_clr_held_run", 32'(RUNNING), 32'h0);
        CLEAR = 1'b0;
        ENABLE = 1'b0;

        // 6: asynchronous reset mid-count
        press();
        ticks(201);
        check_eq("t6_disp_0321", 32'(disp), 32'h0321);
        check_eq("t6_run_pre", 32'(RUNNING), 32'h1);
        #2 RESET = 1'b1;
        #1;
        check_eq("t6_async_disp", 32'(disp), 32'h0000);
        check_eq("t6_async_run", 32'(RUNNING), 32'h0);
        @(negedge CLK) RESET = 1'b0;
        repeat (3) tick_spaced();
        check_eq("t6_post_disp", 32'(disp), 32'h0000);
        check_eq("t6_post_run", 32'(RUNNING), 32'h0);

        check_eq("carry_total", 32'(carry_cnt), 32'd1);
        check_eq("digit_range", 32'(range_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
